// File: rtl/pipe_pkg.sv
// Shared types and pure helper functions for the registered valid/ready skid stage.
package pipe_pkg;

   localparam int unsigned OCC_W = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_e;

   function automatic logic is_fire(input logic valid, input logic ready);
      return valid & ready;
   endfunction

   // Occupancy transition for one edge; the enum encoding doubles as the entry count.
   function automatic skid_state_e next_state(input skid_state_e state,
                                              input logic        in_fire,
                                              input logic        out_fire);
      skid_state_e nxt;
      nxt = state;
      case (state)
         EMPTY: if (in_fire) nxt = ONE;
         ONE: begin
            if (in_fire && !out_fire)      nxt = TWO;
            else if (!in_fire && out_fire) nxt = EMPTY;
         end
         TWO:   if (out_fire) nxt = ONE;
         default: nxt = EMPTY;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Handshake and observation bundle for pipe_skid_stage.
interface pipe_skid_stage_if
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned COUNT_W = 16
);
   logic               in_valid;
   logic               in_ready;
   logic [DATA_W-1:0]  in_data;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  out_data;
   logic [OCC_W-1:0]   occupancy;
   logic [COUNT_W-1:0] xfer_count;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, occupancy, xfer_count
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, occupancy, xfer_count
   );
endinterface

// File: rtl/pipe_skid_stage.sv
// Registered valid/ready stage with a one-entry skid buffer; every output comes
// straight from a flop, so no combinational path crosses the stage.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned COUNT_W = 16
) (
   input logic              clk,
   input logic              rst,
   pipe_skid_stage_if.slave bus
);

   skid_state_e        state_q, state_d;
   logic [DATA_W-1:0]  main_q, skid_q;
   logic [COUNT_W-1:0] xfer_q;
   logic               in_ready_q, out_valid_q;

   logic in_fire, out_fire;
   logic load_main, main_from_skid, load_skid;

   // Next state and register enables.
   always_comb begin
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      in_fire        = is_fire(bus.in_valid, in_ready_q);
      out_fire       = is_fire(out_valid_q, bus.out_ready);
      state_d        = next_state(state_q, in_fire, out_fire);
      case (state_q)
         EMPTY: load_main = in_fire;
         ONE: begin
            load_main = in_fire & out_fire;
            load_skid = in_fire & ~out_fire;
         end
         TWO: begin
            load_main      = out_fire;
            main_from_skid = 1'b1;
         end
         default: ;
      endcase
   end

   // State, payload and counter; in_ready stays low until the first edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         main_q      <= '0;
         skid_q      <= '0;
         xfer_q      <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d != TWO);
         out_valid_q <= (state_d != EMPTY);
         if (load_main) main_q <= main_from_skid ? skid_q : bus.in_data;
         if (load_skid) skid_q <= bus.in_data;
         if (out_fire)  xfer_q <= xfer_q + COUNT_W'(1);
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = main_q;
   assign bus.occupancy  = OCC_W'(state_q);
   assign bus.xfer_count = xfer_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage against a queue-based reference model.
module tb_pipe_skid_stage;

   logic clk = 1'b0;
   logic rst;

   pipe_skid_stage_if #(.DATA_W(8), .COUNT_W(16)) bus ();
   pipe_skid_stage_if #(.DATA_W(8), .COUNT_W(4))  bus4 ();

   pipe_skid_stage #(.DATA_W(8), .COUNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
   pipe_skid_stage #(.DATA_W(8), .COUNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a FIFO of capacity two plus a transfer count.
   logic [7:0]  q[$];
   logic        m_rdy;
   logic [15:0] m_cnt;
   logic [7:0]  m_data;

   task automatic model_reset();
      q.delete();
      m_rdy  = 1'b0;
      m_cnt  = '0;
      m_data = '0;
   endtask

   // Drive one cycle on the main bus and advance the model across the edge.
   task automatic tick(input logic iv, input logic [7:0] id, input logic ordy);
      logic fi, fo;
      bus.in_valid  = iv;
      bus.in_data   = id;
      bus.out_ready = ordy;
      fi = iv && m_rdy;
      fo = (q.size() > 0) && ordy;
      @(posedge clk);
      #1;
      if (fo) begin
         void'(q.pop_front());
         m_cnt = m_cnt + 16'd1;
      end
      if (fi) q.push_back(id);
      if (q.size() > 0) m_data = q[0];
      m_rdy = (q.size() < 2);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b0;
      model_reset();
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.occupancy !== 2'd0 ||
          bus.xfer_count !== 16'd0 || bus.out_data !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_values: ov=%b ir=%b occ=%0d cnt=%0d data=%h, want 0 0 0 0 00",
                  bus.out_valid, bus.in_ready, bus.occupancy, bus.xfer_count, bus.out_data);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready_before_edge: got %b want 0", bus.in_ready);
      end
      tick(1'b0, 8'h00, 1'b0);
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready_after_edge: ir=%b occ=%0d ov=%b want 1 0 0",
                  bus.in_ready, bus.occupancy, bus.out_valid);
      end
   endtask

   task automatic test_streaming();
      logic [15:0] base;
      base = m_cnt;
      for (int i = 1; i <= 16; i++) begin
         tick(1'b1, 8'(i), 1'b1);
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i) || bus.in_ready !== 1'b1 ||
             bus.occupancy !== 2'd1) begin
            n_fail++;
            $display("FAIL stream_word_%0d: ov=%b data=%h ir=%b occ=%0d want 1 %h 1 1",
                     i, bus.out_valid, bus.out_data, bus.in_ready, bus.occupancy, 8'(i));
         end
      end
      tick(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (bus.xfer_count !== base + 16'd16 || bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_count: cnt=%0d occ=%0d ov=%b want %0d 0 0",
                  bus.xfer_count, bus.occupancy, bus.out_valid, base + 16'd16);
      end
   endtask

   task automatic test_backpressure();
      tick(1'b1, 8'hA1, 1'b0);
      tick(1'b1, 8'hA2, 1'b0);
      n_checks++;
      if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_data !== 8'hA1 ||
          bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_full: occ=%0d ir=%b data=%h ov=%b want 2 0 a1 1",
                  bus.occupancy, bus.in_ready, bus.out_data, bus.out_valid);
      end
      // Offered 0xFF while full must be dropped by the handshake and never emerge.
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 8'hFF, 1'b0);
         n_checks++;
         if (bus.out_data !== 8'hA1 || bus.occupancy !== 2'd2 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stall_%0d: data=%h occ=%0d ov=%b want a1 2 1",
                     i, bus.out_data, bus.occupancy, bus.out_valid);
         end
      end
      tick(1'b0, 8'hFF, 1'b1);
      n_checks++;
      if (bus.out_data !== 8'hA2 || bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_second: data=%h occ=%0d ir=%b want a2 1 1",
                  bus.out_data, bus.occupancy, bus.in_ready);
      end
      tick(1'b0, 8'hFF, 1'b1);
      n_checks++;
      if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_data === 8'hFF) begin
         n_fail++;
         $display("FAIL bp_drained: occ=%0d ov=%b data=%h want 0 0 not-ff",
                  bus.occupancy, bus.out_valid, bus.out_data);
      end
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int i = 0; i < 400; i++) begin
         tick(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
         n_checks++;
         if (bus.out_valid !== (q.size() > 0) || bus.in_ready !== m_rdy ||
             bus.occupancy !== 2'(q.size()) || bus.xfer_count !== m_cnt ||
             bus.out_data !== m_data) begin
            n_fail++;
            bad++;
            if (bad <= 5)
               $display("FAIL random_cycle_%0d: ov=%b ir=%b occ=%0d cnt=%0d data=%h want %b %b %0d %0d %h",
                        i, bus.out_valid, bus.in_ready, bus.occupancy, bus.xfer_count, bus.out_data,
                        (q.size() > 0), m_rdy, q.size(), m_cnt, m_data);
         end
      end
      while (q.size() > 0) tick(1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_counter_wrap();
      bus4.out_ready = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         bus4.in_valid = (k <= 17);
         bus4.in_data  = 8'(k);
         tick(1'b0, 8'h00, 1'b0);
         n_checks++;
         if (bus4.xfer_count !== 4'(k - 1)) begin
            n_fail++;
            $display("FAIL wrap_after_%0d_transfers: got %0d want %0d",
                     k - 1, bus4.xfer_count, 4'(k - 1));
         end
      end
      bus4.in_valid  = 1'b0;
      bus4.out_ready = 1'b0;
   endtask

   task automatic test_mid_reset();
      tick(1'b1, 8'h31, 1'b0);
      tick(1'b1, 8'h32, 1'b0);
      n_checks++;
      if (bus.occupancy !== 2'd2) begin
         n_fail++;
         $display("FAIL midrst_fill: occ=%0d want 2", bus.occupancy);
      end
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0 || bus.xfer_count !== 16'd0 ||
          bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_async: ov=%b occ=%0d cnt=%0d ir=%b want 0 0 0 0",
                  bus.out_valid, bus.occupancy, bus.xfer_count, bus.in_ready);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      tick(1'b0, 8'h00, 1'b1);
      tick(1'b1, 8'h5C, 1'b1);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5C || bus.xfer_count !== 16'd0) begin
         n_fail++;
         $display("FAIL midrst_first_out: ov=%b data=%h cnt=%0d want 1 5c 0",
                  bus.out_valid, bus.out_data, bus.xfer_count);
      end
      tick(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (bus.xfer_count !== 16'd1 || bus.occupancy !== 2'd0) begin
         n_fail++;
         $display("FAIL midrst_count: cnt=%0d occ=%0d want 1 0", bus.xfer_count, bus.occupancy);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_random();
      test_counter_wrap();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
